// File: rtl/sprite_blitter.sv
// Sprite blitter: on a rising edge of draw, reads a sprite header and pixels from the
// sprite ROM and emits one clipped, transparency-filtered pixel write per opaque pixel.
module sprite_blitter #(
  parameter int unsigned ROM_SLOT_BITS = 12,
  parameter logic [15:0] TRANSPARENT   = 16'hF81F,
  parameter int unsigned SCREEN_W      = 240,
  parameter int unsigned SCREEN_H      = 320
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       draw,
  input  logic [7:0]                 xOrigin,
  input  logic [8:0]                 yOrigin,
  input  logic [3:0]                 romId,
  output logic                       ready,
  output logic [4+ROM_SLOT_BITS-1:0] romAddr,
  input  logic [15:0]                romData,
  output logic [7:0]                 pixelX,
  output logic [8:0]                 pixelY,
  output logic [15:0]                pixelData,
  output logic                       pixelWrite,
  input  logic                       pixelReady
);

  typedef enum logic [2:0] {
    StIdle, StHdr0, StHdr1, StHdr2, StFetch, StPixel, StWrite, StDone
  } state_e;

  localparam logic [8:0] ScreenW = 9'(SCREEN_W);
  localparam logic [9:0] ScreenH = 10'(SCREEN_H);

  state_e                   state_q, state_d;
  logic                     draw_prev_q;
  logic [7:0]               x_org_q;
  logic [8:0]               y_org_q;
  logic [3:0]               slot_q;
  logic [7:0]               width_q;
  logic [8:0]               height_q;
  logic [7:0]               col_q;
  logic [8:0]               row_q;
  logic [ROM_SLOT_BITS-1:0] offset_q;
  logic [7:0]               pixel_x_q;
  logic [8:0]               pixel_y_q;
  logic [15:0]              pixel_data_q;

  logic       accept, skip, last_col, last_row, last_pixel, advance;
  logic [8:0] sum_x;
  logic [9:0] sum_y;

  // Sums are one bit wider than the origin so off-screen pixels never wrap back on.
  always_comb begin
    sum_x      = {1'b0, x_org_q} + {1'b0, col_q};
    sum_y      = {1'b0, y_org_q} + {1'b0, row_q};
    accept     = draw && !draw_prev_q;
    skip       = (romData == TRANSPARENT) || (sum_x >= ScreenW) || (sum_y >= ScreenH);
    last_col   = (col_q == width_q - 8'd1);
    last_row   = (row_q == height_q - 9'd1);
    last_pixel = last_col && last_row;
    advance    = ((state_q == StPixel) && skip) || ((state_q == StWrite) && pixelReady);
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StHdr0;
      StHdr0:  state_d = StHdr1;
      StHdr1:  state_d = StHdr2;
      StHdr2:  state_d = ((width_q == 8'd0) || (romData[8:0] == 9'd0)) ? StDone : StFetch;
      StFetch: state_d = StPixel;
      StPixel: begin
        if (!skip)           state_d = StWrite;
        else if (last_pixel) state_d = StDone;
        else                 state_d = StFetch;
      end
      StWrite: if (pixelReady) state_d = last_pixel ? StDone : StFetch;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready      = (state_q == StIdle);
    pixelWrite = (state_q == StWrite);
    romAddr    = {slot_q, offset_q};
    pixelX     = pixel_x_q;
    pixelY     = pixel_y_q;
    pixelData  = pixel_data_q;
  end

  // drawPrev resets high so a draw held through reset needs a fresh rising edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      draw_prev_q  <= 1'b1;
      x_org_q      <= '0;
      y_org_q      <= '0;
      slot_q       <= '0;
      width_q      <= '0;
      height_q     <= '0;
      col_q        <= '0;
      row_q        <= '0;
      offset_q     <= '0;
      pixel_x_q    <= '0;
      pixel_y_q    <= '0;
      pixel_data_q <= '0;
    end else begin
      draw_prev_q <= draw;
      if ((state_q == StIdle) && accept) begin
        x_org_q  <= xOrigin;
        y_org_q  <= yOrigin;
        slot_q   <= romId;
        offset_q <= '0;
      end
      if (state_q == StHdr0) offset_q <= ROM_SLOT_BITS'(1);
      if (state_q == StHdr1) width_q <= romData[7:0];
      if (state_q == StHdr2) begin
        height_q <= romData[8:0];
        col_q    <= '0;
        row_q    <= '0;
        offset_q <= ROM_SLOT_BITS'(2);
      end
      if ((state_q == StPixel) && !skip) begin
        pixel_x_q    <= sum_x[7:0];
        pixel_y_q    <= sum_y[8:0];
        pixel_data_q <= romData;
      end
      if (advance && !last_pixel) begin
        offset_q <= offset_q + ROM_SLOT_BITS'(1);
        if (last_col) begin
          col_q <= '0;
          row_q <= row_q + 9'd1;
        end else begin
          col_q <= col_q + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: a per-draw list model of the expected writes and
// completion time, checked every cycle against the pixel-write port.
module tb_sprite_blitter;

  typedef struct packed {
    logic [7:0]  x;
    logic [8:0]  y;
    logic [15:0] d;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        draw = 1'b0;
  logic [7:0]  xOrigin = '0;
  logic [8:0]  yOrigin = '0;
  logic [3:0]  romId = '0;
  logic        ready;
  logic [15:0] romAddr;
  logic [15:0] romData = '0;
  logic [7:0]  pixelX;
  logic [8:0]  pixelY;
  logic [15:0] pixelData;
  logic        pixelWrite;
  logic        pixelReady = 1'b1;

  logic [15:0] rom [65536];
  wr_t         exp_q[$];
  wr_t         obs [16];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;
  int writes_seen = 0;
  int first_wr = -1;
  int stall_on = 1;
  int stall_left = 0;
  int done_k;
  int tmp_cycles, tmp_n;

  sprite_blitter dut (
    .clock      (clock),
    .reset      (reset),
    .draw       (draw),
    .xOrigin    (xOrigin),
    .yOrigin    (yOrigin),
    .romId      (romId),
    .ready      (ready),
    .romAddr    (romAddr),
    .romData    (romData),
    .pixelX     (pixelX),
    .pixelY     (pixelY),
    .pixelData  (pixelData),
    .pixelWrite (pixelWrite),
    .pixelReady (pixelReady)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc++;
    romData <= rom[romAddr];
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Backpressure: hold pixelReady low for stall_left cycles on write number stall_on.
  always @(posedge clock) begin
    #1;
    if (pixelWrite && (writes_seen == stall_on) && (stall_left > 0)) begin
      pixelReady = 1'b0;
      stall_left--;
    end else begin
      pixelReady = 1'b1;
    end
  end

  always @(negedge clock) begin
    if (!reset && pixelWrite) begin
      chk("ready_low_while_writing", ready, 0);
      chk("write_was_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        chk("pixelX", pixelX, exp_q[0].x);
        chk("pixelY", pixelY, exp_q[0].y);
        chk("pixelData", pixelData, exp_q[0].d);
      end
      if (first_wr < 0) first_wr = cyc - t0;
      if (pixelReady) begin
        if (writes_seen < 16) obs[writes_seen] = {pixelX, pixelY, pixelData};
        writes_seen++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
  end

  // Expected writes in row-major order; 5 cycles of header/done overhead,
  // 2 cycles per skipped pixel, 3 per written pixel (before backpressure).
  task automatic build_model(input logic [3:0] id, input logic [7:0] x0, input logic [8:0] y0,
                             output int cycles, output int nwr);
    int base, w, h, xx, yy;
    logic [15:0] d;
    base = int'(id) * 4096;
    w = int'(rom[base][7:0]);
    h = int'(rom[base+1][8:0]);
    cycles = 5;
    nwr = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        d = rom[base + 2 + r * w + c];
        xx = int'(x0) + c;
        yy = int'(y0) + r;
        if (d != 16'hF81F && xx < 240 && yy < 320) begin
          exp_q.push_back({xx[7:0], yy[8:0], d});
          cycles += 3;
          nwr++;
        end else begin
          cycles += 2;
        end
      end
    end
  endtask

  task automatic run_draw(input string name, input logic [3:0] id, input logic [7:0] x0,
                          input logic [8:0] y0, input int hold, input int pulse_at,
                          input int stall_n, output int dk);
    int exp_done, wr_exp;
    build_model(id, x0, y0, exp_done, wr_exp);
    exp_done += stall_n;
    stall_on = 1;
    stall_left = stall_n;
    writes_seen = 0;
    first_wr = -1;
    @(posedge clock); #1;
    draw = 1'b1;
    xOrigin = x0;
    yOrigin = y0;
    romId = id;
    t0 = cyc;
    dk = -1;
    for (int k = 1; k <= 2000; k++) begin
      @(posedge clock); #1;
      draw = (k < hold) || (k == pulse_at);
      if (k == 1) chk({name, "_ready_low_c1"}, ready, 0);
      if (dk < 0 && ready) dk = k;
      else if (dk >= 0) chk({name, "_ready_stays_high"}, ready, 1);
      if (dk >= 0 && k >= hold && k >= dk + 3 && k > pulse_at) break;
    end
    draw = 1'b0;
    chk({name, "_done_cycle"}, dk, exp_done);
    chk({name, "_write_count"}, writes_seen, wr_exp);
    chk({name, "_all_writes_seen"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) rom[i] = 16'h0000;
    // slot 1: 2x2 opaque
    rom[16'h1000] = 16'd2; rom[16'h1001] = 16'd2;
    rom[16'h1002] = 16'hAAAA; rom[16'h1003] = 16'hBBBB;
    rom[16'h1004] = 16'hCCCC; rom[16'h1005] = 16'hDDDD;
    // slot 2: 3x1 with transparent middle
    rom[16'h2000] = 16'd3; rom[16'h2001] = 16'd1;
    rom[16'h2002] = 16'h0A0A; rom[16'h2003] = 16'hF81F; rom[16'h2004] = 16'h0C0C;
    // slot 3: 4x1
    rom[16'h3000] = 16'd4; rom[16'h3001] = 16'd1;
    rom[16'h3002] = 16'h0001; rom[16'h3003] = 16'h0002;
    rom[16'h3004] = 16'h0003; rom[16'h3005] = 16'h0004;
    // slot 4: 1x2
    rom[16'h4000] = 16'd1; rom[16'h4001] = 16'd2;
    rom[16'h4002] = 16'h1234; rom[16'h4003] = 16'h5678;
    // slot 5: zero width
    rom[16'h5000] = 16'd0; rom[16'h5001] = 16'd3;
    // slot 6: 3x1 for backpressure
    rom[16'h6000] = 16'd3; rom[16'h6001] = 16'd1;
    rom[16'h6002] = 16'h0111; rom[16'h6003] = 16'h0222; rom[16'h6004] = 16'h0333;

    repeat (3) @(posedge clock);
    #1;
    chk("reset_ready", ready, 1);
    chk("reset_pixelWrite", pixelWrite, 0);
    chk("reset_pixelX", pixelX, 0);
    chk("reset_pixelY", pixelY, 0);
    chk("reset_pixelData", pixelData, 0);
    chk("reset_romAddr", romAddr, 0);
    reset = 1'b0;
    repeat (2) @(posedge clock);

    run_draw("opaque2x2", 4'd1, 8'd10, 9'd20, 1, -1, 0, done_k);
    chk("opaque2x2_first_write_cycle", first_wr, 6);
    chk("opaque2x2_ready_cycle_literal", done_k, 17);
    chk("opaque2x2_w0", obs[0], {8'd10, 9'd20, 16'hAAAA});
    chk("opaque2x2_w1", obs[1], {8'd11, 9'd20, 16'hBBBB});
    chk("opaque2x2_w2", obs[2], {8'd10, 9'd21, 16'hCCCC});
    chk("opaque2x2_w3", obs[3], {8'd11, 9'd21, 16'hDDDD});

    run_draw("transparent", 4'd2, 8'd50, 9'd60, 1, -1, 0, done_k);
    chk("transparent_w1_x", obs[1].x, 52);

    run_draw("clip_x", 4'd3, 8'd238, 9'd5, 1, -1, 0, done_k);
    chk("clip_x_w0_x", obs[0].x, 238);
    chk("clip_x_w1_x", obs[1].x, 239);

    run_draw("clip_y", 4'd4, 8'd100, 9'd319, 1, -1, 0, done_k);
    chk("clip_y_w0_y", obs[0].y, 319);

    run_draw("zero_size", 4'd5, 8'd0, 9'd0, 1, -1, 0, done_k);
    chk("zero_size_ready_cycle_literal", done_k, 5);

    run_draw("backpressure", 4'd6, 8'd0, 9'd0, 1, -1, 5, done_k);
    chk("backpressure_ready_cycle_literal", done_k, 19);

    run_draw("held_draw", 4'd1, 8'd10, 9'd20, 40, -1, 0, done_k);
    run_draw("busy_edge", 4'd3, 8'd0, 9'd0, 1, 8, 0, done_k);

    // Reset in the middle of a stalled write, with draw held high throughout.
    build_model(4'd1, 8'd10, 9'd20, tmp_cycles, tmp_n);
    stall_on = 0;
    stall_left = 1000;
    writes_seen = 0;
    @(posedge clock); #1;
    draw = 1'b1; xOrigin = 8'd10; yOrigin = 9'd20; romId = 4'd1; t0 = cyc;
    for (int k = 0; k < 50; k++) begin
      @(posedge clock); #1;
      if (pixelWrite) break;
    end
    chk("rst_reached_write", pixelWrite, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rst_pixelWrite", pixelWrite, 0);
    chk("rst_ready", ready, 1);
    chk("rst_pixelX", pixelX, 0);
    chk("rst_pixelY", pixelY, 0);
    chk("rst_pixelData", pixelData, 0);
    chk("rst_romAddr", romAddr, 0);
    reset = 1'b0;
    exp_q.delete();
    stall_left = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      chk("rst_no_retrigger", ready, 1);
    end
    draw = 1'b0;
    @(posedge clock);
    run_draw("after_reset", 4'd2, 8'd50, 9'd60, 1, -1, 0, done_k);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
